// File: rtl/bdiff_pkg.sv
// ============================================================================
// Module      : bdiff_pkg
// Description : Shared types and helpers for the Boolean-difference sweep
//               controller: FSM state encoding and last-vector helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bdiff_pkg;

   // Sweep controller FSM states
   typedef enum logic [2:0] {
      SWEEP_IDLE   = 3'd0,
      SWEEP_DRIVE  = 3'd1,
      SWEEP_SAMPLE = 3'd2,
      SWEEP_FLUSH  = 3'd3,
      SWEEP_DONE   = 3'd4
   } sweep_state_t;

   // Highest vector value of an n-bit sweep (2^n - 1)
   function automatic int unsigned sweep_last(input int unsigned n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bdiff_match_fifo.sv
// ============================================================================
// Module      : bdiff_match_fifo
// Description : Synchronous FIFO holding matching vectors. A push is refused
//               when full, even if a pop happens in the same cycle. The head
//               entry is presented combinationally from the storage array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bdiff_match_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             last_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign last_o  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(1));
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage and pointer update; storage cleared on reset so the head reads 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bdiff_sweep_ctrl.sv
// ============================================================================
// Module      : bdiff_sweep_ctrl
// Description : Exhaustive sweep controller. Drives every N_VARS-bit vector
//               in ascending order into an external combinational evaluator,
//               samples its result after SETTLE_CYCLES and streams matching
//               vectors out through a valid/ready FIFO.
//               Optional feature macro: BDIFF_MATCH_COUNT_EN adds the
//               match_count port and its saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bdiff_sweep_ctrl
   import bdiff_pkg::*;
#(
   parameter int N_VARS        = 3,
   parameter int SETTLE_CYCLES = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_VARS-1:0] eval_vec,
   input  logic              eval_result,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [N_VARS-1:0] m_data,
   output logic              busy,
   output logic              done
`ifdef BDIFF_MATCH_COUNT_EN
   ,
   output logic [N_VARS:0]   match_count
`endif
);

   localparam int                SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [N_VARS-1:0] LAST_VEC    = N_VARS'(sweep_last(N_VARS));

   sweep_state_t      state_q;
   logic [N_VARS-1:0] eval_vec_q;
   logic [SW-1:0]     settle_q;
   logic              busy_q;
   logic              done_q;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_last;
   logic              flush_ok;

   assign fifo_push = (state_q == SWEEP_SAMPLE) && eval_result && !fifo_full;
   assign fifo_pop  = !fifo_empty && m_ready;
   // FIFO counts as drained when it is empty or its last entry leaves this edge
   assign flush_ok  = fifo_empty || (fifo_last && fifo_pop);

   assign eval_vec = eval_vec_q;
   assign m_valid  = !fifo_empty;
   assign busy     = busy_q;
   assign done     = done_q;

   // Sweep FSM: vector stepping, settle timing and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SWEEP_IDLE;
         eval_vec_q <= '0;
         settle_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SWEEP_IDLE: begin
               if (start) begin
                  eval_vec_q <= '0;
                  settle_q   <= SETTLE_LOAD;
                  busy_q     <= 1'b1;
                  state_q    <= SWEEP_DRIVE;
               end
            end
            SWEEP_DRIVE: begin
               if (settle_q == '0) begin
                  state_q <= SWEEP_SAMPLE;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            SWEEP_SAMPLE: begin
               // A match with a full FIFO holds the vector and re-samples
               if (!eval_result || !fifo_full) begin
                  if (eval_vec_q == LAST_VEC) begin
                     state_q <= SWEEP_FLUSH;
                  end else begin
                     eval_vec_q <= eval_vec_q + 1'b1;
                     settle_q   <= SETTLE_LOAD;
                     state_q    <= SWEEP_DRIVE;
                  end
               end
            end
            SWEEP_FLUSH: begin
               if (flush_ok) begin
                  state_q <= SWEEP_DONE;
               end
            end
            SWEEP_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= SWEEP_IDLE;
            end
            default: begin
               state_q <= SWEEP_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BDIFF_MATCH_COUNT_EN
   localparam logic [N_VARS:0] MC_MAX = {1'b1, {N_VARS{1'b0}}};

   logic [N_VARS:0] match_cnt_q;

   // Matches of the current sweep, cleared on start and saturating at 2^N_VARS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt_q <= '0;
      end else if ((state_q == SWEEP_IDLE) && start) begin
         match_cnt_q <= '0;
      end else if (fifo_push && (match_cnt_q != MC_MAX)) begin
         match_cnt_q <= match_cnt_q + 1'b1;
      end
   end

   assign match_count = match_cnt_q;
`endif

   bdiff_match_fifo #(
      .WIDTH (N_VARS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (eval_vec_q),
      .pop_i   (fifo_pop),
      .rdata_o (m_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .last_o  (fifo_last)
   );

endmodule

`default_nettype wire

// File: tb/tb_bdiff_sweep_ctrl.sv
// ============================================================================
// Module      : tb_bdiff_sweep_ctrl
// Description : Directed self-checking bench for bdiff_sweep_ctrl. Cycle k
//               counts rising edges after the edge that samples start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bdiff_sweep_ctrl;

   localparam int NV = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          start3;
   logic          m_ready;
   logic [NV-1:0] eval_vec, eval_vec3;
   logic [NV-1:0] m_data, m_data3;
   logic          eval_result, eval_result3;
   logic          m_valid, m_valid3;
   logic          busy, busy3;
   logic          done, done3;
`ifdef BDIFF_MATCH_COUNT_EN
   logic [NV:0]   match_count, match_count3;
`endif

   int            eval_mode;   // 0: constant 0, 1: carry difference, 2: constant 1
   int            checks   = 0;
   int            failures = 0;
   logic [NV-1:0] got[$];
   logic          any_valid;
   int            snap_vec, snap_valid, snap_data, snap_busy;

   always #5 clk = ~clk;

   // Ripple carry of a full adder bit
   function automatic logic carry(input logic a, input logic b, input logic c);
      return (a & b) | (c & (a ^ b));
   endfunction

   // Evaluator models: the carry difference w.r.t. Cin is 1 exactly when A != B
   function automatic logic evaluate(input int mode, input logic [NV-1:0] v);
      case (mode)
         1:       return carry(v[1], v[0], 1'b0) ^ carry(v[1], v[0], 1'b1);
         2:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign eval_result  = evaluate(eval_mode, eval_vec);
   assign eval_result3 = eval_vec3[0];

   bdiff_sweep_ctrl #(.N_VARS(NV), .SETTLE_CYCLES(1), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .eval_vec    (eval_vec),
      .eval_result (eval_result),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .busy        (busy),
      .done        (done)
`ifdef BDIFF_MATCH_COUNT_EN
      ,
      .match_count (match_count)
`endif
   );

   bdiff_sweep_ctrl #(.N_VARS(NV), .SETTLE_CYCLES(3), .FIFO_DEPTH(4)) dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start3),
      .eval_vec    (eval_vec3),
      .eval_result (eval_result3),
      .m_valid     (m_valid3),
      .m_ready     (m_ready),
      .m_data      (m_data3),
      .busy        (busy3),
      .done        (done3)
`ifdef BDIFF_MATCH_COUNT_EN
      ,
      .match_count (match_count3)
`endif
   );

   task automatic check(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Compare the collected stream against an expected list
   task automatic check_stream(input string tag, input int exp_q[$]);
      check({tag, "_len"}, got.size(), exp_q.size());
      foreach (exp_q[i]) begin
         check($sformatf("%s_%0d", tag, i), (i < got.size()) ? int'(got[i]) : -1, exp_q[i]);
      end
   endtask

   // One sweep on dut (sel 0) or dut3 (sel 1); returns the cycle done is seen
   task automatic run_sweep(input int sel, input int ready_at, input int restart_at,
                            output int done_at);
      int k;
      got.delete();
      any_valid = 1'b0;
      done_at   = -1;
      @(negedge clk);
      m_ready = (ready_at <= 0);
      if (sel == 0) start = 1'b1; else start3 = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start3 = 1'b0;
      k = 0;
      while ((k < 400) && (done_at < 0)) begin
         m_ready = (k >= ready_at);
         if (sel == 0) start = (k == restart_at);
         if (k == ready_at - 1) begin
            snap_vec   = int'(sel == 0 ? eval_vec : eval_vec3);
            snap_valid = int'(sel == 0 ? m_valid : m_valid3);
            snap_data  = int'(sel == 0 ? m_data : m_data3);
            snap_busy  = int'(sel == 0 ? busy : busy3);
         end
         if (sel == 0) begin
            if (m_valid) any_valid = 1'b1;
            if (m_valid && m_ready) got.push_back(m_data);
            if (done) done_at = k;
         end else begin
            if (m_valid3) any_valid = 1'b1;
            if (m_valid3 && m_ready) got.push_back(m_data3);
            if (done3) done_at = k;
         end
         @(negedge clk);
         k++;
      end
      start   = 1'b0;
      m_ready = 1'b1;
   endtask

   initial begin
      int dcyc;
      rst_n     = 1'b0;
      start     = 1'b0;
      start3    = 1'b0;
      m_ready   = 1'b1;
      eval_mode = 0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_eval_vec", int'(eval_vec), 0);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data", int'(m_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
`ifdef BDIFF_MATCH_COUNT_EN
      check("rst_match_count", int'(match_count), 0);
`endif
      rst_n = 1'b1;

      // Carry-difference evaluator, consumer always ready
      eval_mode = 1;
      run_sweep(0, 0, -1, dcyc);
      check("diff_done_cycle", dcyc, 18);
      check_stream("diff_stream", '{1, 2, 5, 6});
`ifdef BDIFF_MATCH_COUNT_EN
      check("diff_match_count", int'(match_count), 4);
`endif
      check("diff_busy_after", int'(busy), 0);

      // Constant-0 evaluator: nothing streamed
      eval_mode = 0;
      run_sweep(0, 0, -1, dcyc);
      check("zero_done_cycle", dcyc, 18);
      check("zero_no_valid", int'(any_valid), 0);
`ifdef BDIFF_MATCH_COUNT_EN
      check("zero_match_count", int'(match_count), 0);
`endif

      // Constant-1 evaluator with consumer stalled until cycle 18
      eval_mode = 2;
      run_sweep(0, 18, -1, dcyc);
      check("stall_eval_vec", snap_vec, 4);
      check("stall_m_valid", snap_valid, 1);
      check("stall_head", snap_data, 0);
      check("stall_busy", snap_busy, 1);
      check_stream("stall_stream", '{0, 1, 2, 3, 4, 5, 6, 7});
      check("stall_done_seen", int'(dcyc > 18), 1);
`ifdef BDIFF_MATCH_COUNT_EN
      check("stall_match_count", int'(match_count), 8);
`endif

      // Second start while busy has no effect
      eval_mode = 1;
      run_sweep(0, 0, 5, dcyc);
      check("restart_done_cycle", dcyc, 18);
      check_stream("restart_stream", '{1, 2, 5, 6});

      // Reset in SAMPLE with two entries queued
      eval_mode = 2;
      @(negedge clk);
      m_ready = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_eval_vec", int'(eval_vec), 2);
      check("pre_rst_m_valid", int'(m_valid), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_m_valid", int'(m_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_eval_vec", int'(eval_vec), 0);
      check("mid_rst_m_data", int'(m_data), 0);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      eval_mode = 1;
      run_sweep(0, 0, -1, dcyc);
      check("post_rst_done_cycle", dcyc, 18);
      check_stream("post_rst_stream", '{1, 2, 5, 6});

      // SETTLE_CYCLES = 3 instance, evaluator = eval_vec[0]
      run_sweep(1, 0, -1, dcyc);
      check("settle3_done_cycle", dcyc, 34);
      check_stream("settle3_stream", '{1, 3, 5, 7});
`ifdef BDIFF_MATCH_COUNT_EN
      check("settle3_match_count", int'(match_count3), 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
